// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a show-ahead FIFO and a valid/ready consumer port.
// Sticky frame_err/overrun flags; a set in the same cycle as err_clear wins.
`timescale 1ns/1ps
module uart_rx_fifo #(
    parameter int CLK_HZ = 25_500_000,
    parameter int BAUD   = 115_200,
    parameter int DEPTH  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    input  logic       err_clear,
    output logic       busy
);
    localparam int CPB  = CLK_HZ / BAUD;
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB);
    localparam int AW   = $clog2(DEPTH);

    localparam logic [CW-1:0] HALF_LAST  = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_LAST   = CW'(CPB - 1);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] BRK   = 3'd4;

    logic          sync1;
    logic          rxs;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic stop_sample;
    logic push_req;
    logic frame_set;
    logic full;
    logic pop;
    logic push_ok;
    logic overrun_set;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rxd;
            rxs   <= sync1;
        end
    end

    // Receiver FSM: cnt times the half-bit to the start midpoint, then full bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!rxs) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shreg   <= {rxs, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= rxs ? IDLE : BRK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BRK: begin
                    if (rxs) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A full FIFO still accepts the byte when the consumer pops in the same cycle.
    always_comb begin
        stop_sample = (state == STOP) && (cnt == BIT_LAST);
        push_req    = stop_sample && rxs;
        frame_set   = stop_sample && !rxs;
        full        = (count == FULL_COUNT);
        pop         = rx_valid && rx_ready;
        push_ok     = push_req && (!full || pop);
        overrun_set = push_req && !push_ok;
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= shreg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (frame_set) begin
                frame_err <= 1'b1;
            end else if (err_clear) begin
                frame_err <= 1'b0;
            end
            if (overrun_set) begin
                overrun <= 1'b1;
            end else if (err_clear) begin
                overrun <= 1'b0;
            end
        end
    end

    // Gating the head with rx_valid keeps rx_data at zero out of reset.
    always_comb begin
        rx_valid = (count != '0);
        rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;
        busy     = (state != IDLE);
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised bench for uart_rx_fifo: a queue-based model predicts every popped
// byte and the sticky flags; cycle-exact checks cover byte latency and pop timing.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
    localparam int  CLK_HZ  = 1_600_000;
    localparam int  BAUD    = 100_000;
    localparam int  DEPTH   = 16;
    localparam int  CPB     = CLK_HZ / BAUD;
    localparam int  HALF    = CPB / 2;
    localparam real BIT_NS  = 10.0 * CPB;
    localparam real FAST_NS = BIT_NS * 0.98;
    // Edges after the launch edge: two synchroniser stages, the detecting edge,
    // half a bit to the start midpoint, then nine full bits to the stop midpoint.
    localparam int  STOP_EDGE = 3 + HALF + 9 * CPB;

    logic       clk = 1'b0;
    logic       reset;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       err_clear;
    logic       busy;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic       exp_overrun;
    logic [7:0] mon_exp;

    uart_rx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .rxd(rxd),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .frame_err(frame_err),
        .overrun(overrun),
        .err_clear(err_clear),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit, input real bit_ns);
        rxd = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rxd = data[i];
            #(bit_ns);
        end
        rxd = stop_bit;
        #(bit_ns);
    endtask

    task automatic alignEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic modelFrame(input logic [7:0] d, input bit pop_same);
        if (rx_ready || pop_same || exp_q.size() < DEPTH) exp_q.push_back(d);
        else exp_overrun = 1'b1;
    endtask

    task automatic sendFrame(input logic [7:0] d);
        modelFrame(d, 1'b0);
        alignEdge();
        applyStimulus(d, 1'b1, BIT_NS);
    endtask

    task automatic pulseReady();
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
    endtask

    task automatic pulseClear();
        err_clear = 1'b1;
        @(posedge clk);
        #1;
        err_clear = 1'b0;
    endtask

    task automatic waitDrain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput(tag, exp_q.size(), 0);
        waitCycles(2);
    endtask

    // Every handshake pops the model queue and compares the head byte.
    always @(negedge clk) begin
        if (reset === 1'b0 && rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("pop_unexpected", exp_q.size(), 1);
            end else begin
                mon_exp = exp_q.pop_front();
                checkOutput("pop_data", rx_data, mon_exp);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL global_timeout: got still running, expected finished");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin
        logic [7:0] d;
        reset = 1'b1;
        rxd = 1'b1;
        rx_ready = 1'b0;
        err_clear = 1'b0;
        exp_overrun = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        checkOutput("reset_valid", rx_valid, 0);
        checkOutput("reset_data", rx_data, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_frame_err", frame_err, 0);
        checkOutput("reset_overrun", overrun, 0);

        sendFrame(8'h12);
        waitCycles(2);
        checkOutput("pre_reset_valid", rx_valid, exp_q.size() != 0);
        checkOutput("pre_reset_data", rx_data, exp_q[0]);

        fork
            begin
                alignEdge();
                applyStimulus(8'hC3, 1'b1, BIT_NS);
            end
            begin
                alignEdge();
                waitCycles(60);
                reset = 1'b1;
                exp_q.delete();
                #1;
                checkOutput("midreset_busy", busy, 0);
                checkOutput("midreset_valid", rx_valid, 0);
                checkOutput("midreset_data", rx_data, 0);
                checkOutput("midreset_frame_err", frame_err, 0);
                checkOutput("midreset_overrun", overrun, 0);
            end
        join
        waitCycles(2);
        reset = 1'b0;
        waitCycles(5);

        sendFrame(8'h3C);
        waitCycles(2);
        checkOutput("after_reset_valid", rx_valid, 1);
        checkOutput("after_reset_data", rx_data, 8'h3C);
        pulseReady();
        checkOutput("after_reset_pop_valid", rx_valid, exp_q.size() != 0);

        modelFrame(8'h55, 1'b0);
        fork
            begin
                alignEdge();
                applyStimulus(8'h55, 1'b1, BIT_NS);
            end
            begin
                @(posedge clk);
                repeat (STOP_EDGE - 1) @(posedge clk);
                #1;
                checkOutput("single_valid_before", rx_valid, 0);
                @(posedge clk);
                #1;
                checkOutput("single_valid_after", rx_valid, 1);
                checkOutput("single_data", rx_data, 8'h55);
            end
        join
        pulseReady();
        checkOutput("single_pop_valid", rx_valid, exp_q.size() != 0);

        rx_ready = 1'b1;
        modelFrame(8'h00, 1'b0);
        modelFrame(8'hFF, 1'b0);
        modelFrame(8'hA5, 1'b0);
        alignEdge();
        applyStimulus(8'h00, 1'b1, FAST_NS);
        applyStimulus(8'hFF, 1'b1, FAST_NS);
        applyStimulus(8'hA5, 1'b1, FAST_NS);
        waitDrain("b2b_drain");
        checkOutput("b2b_frame_err", frame_err, 0);
        checkOutput("b2b_overrun", overrun, exp_overrun);

        alignEdge();
        rxd = 1'b0;
        waitCycles(4);
        checkOutput("glitch_busy_high", busy, 1);
        waitCycles(4);
        rxd = 1'b1;
        waitCycles(20);
        checkOutput("glitch_busy_low", busy, 0);
        checkOutput("glitch_valid", rx_valid, exp_q.size() != 0);

        rx_ready = 1'b0;
        alignEdge();
        applyStimulus(8'h81, 1'b0, BIT_NS);
        waitCycles(50);
        checkOutput("ferr_set", frame_err, 1);
        checkOutput("ferr_busy", busy, 1);
        checkOutput("ferr_valid_mid", rx_valid, 0);
        waitCycles(50);
        checkOutput("ferr_valid_held", rx_valid, 0);
        rxd = 1'b1;
        waitCycles(5);
        checkOutput("ferr_idle_busy", busy, 0);
        checkOutput("ferr_valid_end", rx_valid, 0);
        pulseClear();
        checkOutput("ferr_cleared", frame_err, 0);

        for (int i = 1; i <= 17; i++) sendFrame(8'(i));
        waitCycles(2);
        checkOutput("ovr_set", overrun, exp_overrun);
        checkOutput("ovr_valid", rx_valid, 1);
        checkOutput("ovr_head", rx_data, exp_q[0]);
        rx_ready = 1'b1;
        waitDrain("ovr_drain");
        waitCycles(5);
        checkOutput("ovr_empty", rx_valid, 0);
        pulseClear();
        exp_overrun = 1'b0;
        checkOutput("ovr_cleared", overrun, exp_overrun);

        for (int i = 0; i < 20; i++) begin
            d = 8'($urandom);
            sendFrame(d);
            waitCycles(int'($urandom_range(0, 3)));
        end
        waitDrain("wrap_drain");
        checkOutput("wrap_overrun", overrun, exp_overrun);
        checkOutput("wrap_frame_err", frame_err, 0);

        rx_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) sendFrame(8'($urandom));
        waitCycles(2);
        checkOutput("full_valid", rx_valid, 1);
        checkOutput("full_overrun_pre", overrun, 0);
        modelFrame(8'h77, 1'b1);
        fork
            begin
                alignEdge();
                applyStimulus(8'h77, 1'b1, BIT_NS);
            end
            begin
                @(posedge clk);
                repeat (STOP_EDGE - 1) @(posedge clk);
                #1 rx_ready = 1'b1;
                @(posedge clk);
                #1 rx_ready = 1'b0;
            end
        join
        waitCycles(2);
        checkOutput("full_pop_overrun", overrun, exp_overrun);
        checkOutput("full_pop_valid", rx_valid, 1);
        rx_ready = 1'b1;
        waitDrain("full_pop_drain");
        waitCycles(3);
        checkOutput("full_pop_empty", rx_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
